// File: rtl/jtag_pkg.sv
// JTAG TAP shared definitions.
// State encoding and fixed instruction opcodes.
package jtag_pkg;

    typedef enum logic [3:0] {
        ST_TLR      = 4'h0,
        ST_RTI      = 4'h1,
        ST_SEL_DR   = 4'h2,
        ST_CAP_DR   = 4'h3,
        ST_SHIFT_DR = 4'h4,
        ST_EXIT1_DR = 4'h5,
        ST_PAUSE_DR = 4'h6,
        ST_EXIT2_DR = 4'h7,
        ST_UPD_DR   = 4'h8,
        ST_SEL_IR   = 4'h9,
        ST_CAP_IR   = 4'ha,
        ST_SHIFT_IR = 4'hb,
        ST_EXIT1_IR = 4'hc,
        ST_PAUSE_IR = 4'hd,
        ST_EXIT2_IR = 4'he,
        ST_UPD_IR   = 4'hf
    } tap_state_e;

    localparam int unsigned OP_IDCODE  = 1;
    localparam logic [31:0] OP_BYPASS  = '1;
    localparam int unsigned IDCODE_LEN = 32;

endpackage

// File: rtl/jtag_tap_fsm.sv
// JTAG TAP 16-state controller.
// Advances on tck rise per tms; exposes one-hot state flags.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic tck,
    input  logic trst,
    input  logic tms,
    output logic tlr,
    output logic capture_ir,
    output logic shift_ir,
    output logic update_ir,
    output logic capture_dr,
    output logic shift_dr,
    output logic update_dr
);

    tap_state_e state;
    tap_state_e state_nxt;

    // State register, returns to Test-Logic-Reset on trst
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) state <= ST_TLR;
        else       state <= state_nxt;
    end

    // Next-state transitions and per-state flags
    always_comb begin
        state_nxt  = state;
        tlr        = 1'b0;
        capture_ir = 1'b0;
        shift_ir   = 1'b0;
        update_ir  = 1'b0;
        capture_dr = 1'b0;
        shift_dr   = 1'b0;
        update_dr  = 1'b0;
        unique case (state)
            ST_TLR: begin
                tlr       = 1'b1;
                state_nxt = tms ? ST_TLR : ST_RTI;
            end
            ST_RTI:      state_nxt = tms ? ST_SEL_DR : ST_RTI;
            ST_SEL_DR:   state_nxt = tms ? ST_SEL_IR : ST_CAP_DR;
            ST_CAP_DR: begin
                capture_dr = 1'b1;
                state_nxt  = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
            end
            ST_SHIFT_DR: begin
                shift_dr  = 1'b1;
                state_nxt = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
            end
            ST_EXIT1_DR: state_nxt = tms ? ST_UPD_DR : ST_PAUSE_DR;
            ST_PAUSE_DR: state_nxt = tms ? ST_EXIT2_DR : ST_PAUSE_DR;
            ST_EXIT2_DR: state_nxt = tms ? ST_UPD_DR : ST_SHIFT_DR;
            ST_UPD_DR: begin
                update_dr = 1'b1;
                state_nxt = tms ? ST_SEL_DR : ST_RTI;
            end
            ST_SEL_IR:   state_nxt = tms ? ST_TLR : ST_CAP_IR;
            ST_CAP_IR: begin
                capture_ir = 1'b1;
                state_nxt  = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
            end
            ST_SHIFT_IR: begin
                shift_ir  = 1'b1;
                state_nxt = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
            end
            ST_EXIT1_IR: state_nxt = tms ? ST_UPD_IR : ST_PAUSE_IR;
            ST_PAUSE_IR: state_nxt = tms ? ST_EXIT2_IR : ST_PAUSE_IR;
            ST_EXIT2_IR: state_nxt = tms ? ST_UPD_IR : ST_SHIFT_IR;
            ST_UPD_IR: begin
                update_ir = 1'b1;
                state_nxt = tms ? ST_SEL_DR : ST_RTI;
            end
            default:     state_nxt = ST_TLR;
        endcase
    end

endmodule

// File: rtl/jtag_tap_multi_dr.sv
// JTAG TAP with IDCODE, BYPASS and N_USER user data registers.
// One shared DR shift register; tdo launched on tck fall.
module jtag_tap_multi_dr
    import jtag_pkg::*;
#(
    parameter int          IR_WIDTH      = 4,
    parameter int          N_USER        = 2,
    parameter int          USER_DR_WIDTH = 32,
    parameter logic [31:0] IDCODE_VAL    = 32'h1000_0001,
    parameter int          USER_BASE     = 2
) (
    input  logic                            tck,
    input  logic                            trst,
    input  logic                            tms,
    input  logic                            tdi,
    output logic                            tdo,
    output logic                            tdo_en,
    output logic [IR_WIDTH-1:0]             ir_out,
    input  logic [N_USER*USER_DR_WIDTH-1:0] user_capture_data,
    output logic [N_USER*USER_DR_WIDTH-1:0] user_update_data,
    output logic [N_USER-1:0]               user_update_strobe,
    output logic                            tap_reset
);

    localparam int W   = USER_DR_WIDTH;
    localparam int DRW = (W > 32) ? W : 32;

    localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(OP_IDCODE);
    localparam logic [IR_WIDTH-1:0] IR_BYPASS  = OP_BYPASS[IR_WIDTH-1:0];
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

    logic tlr;
    logic capture_ir;
    logic shift_ir;
    logic update_ir;
    logic capture_dr;
    logic shift_dr;
    logic update_dr;

    logic [IR_WIDTH-1:0] ir_sr;
    logic [DRW-1:0]      dr_sr;
    logic [DRW-1:0]      dr_cap;
    logic [DRW-1:0]      dr_shift;
    logic                sel_idcode;
    logic [N_USER-1:0]   user_sel;

    jtag_tap_fsm u_fsm (
        .tck        (tck),
        .trst       (trst),
        .tms        (tms),
        .tlr        (tlr),
        .capture_ir (capture_ir),
        .shift_ir   (shift_ir),
        .update_ir  (update_ir),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr)
    );

    assign tap_reset = tlr;

    // Instruction decode; anything not IDCODE or a user opcode is BYPASS
    always_comb begin
        sel_idcode = (ir_out == IR_IDCODE);
        user_sel   = '0;
        for (int i = 0; i < N_USER; i++) begin
            user_sel[i] = !sel_idcode && (ir_out != IR_BYPASS) &&
                          (ir_out == IR_WIDTH'(USER_BASE + i));
        end
    end

    // Capture value and length-aware shift of the selected DR
    always_comb begin
        dr_cap   = '0;
        dr_shift = dr_sr >> 1;
        for (int i = 0; i < N_USER; i++) begin
            if (user_sel[i]) dr_cap = DRW'(user_capture_data[i*W +: W]);
        end
        unique case (1'b1)
            sel_idcode: begin
                dr_cap                 = DRW'(IDCODE_VAL);
                dr_shift[IDCODE_LEN-1] = tdi;
            end
            (|user_sel): dr_shift[W-1] = tdi;
            default:     dr_shift[0]   = tdi;
        endcase
    end

    // IR shift register and active instruction
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            ir_sr  <= '0;
            ir_out <= IR_IDCODE;
        end else begin
            if (tlr)        ir_out <= IR_IDCODE;
            if (update_ir)  ir_out <= ir_sr;
            if (capture_ir) ir_sr  <= IR_CAPTURE;
            if (shift_ir)   ir_sr  <= {tdi, ir_sr[IR_WIDTH-1:1]};
        end
    end

    // Shared DR shift register
    always_ff @(posedge tck or negedge trst) begin
        if (!trst)           dr_sr <= '0;
        else if (capture_dr) dr_sr <= dr_cap;
        else if (shift_dr)   dr_sr <= dr_shift;
    end

    // User update registers with a one-cycle strobe per update
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            user_update_data   <= '0;
            user_update_strobe <= '0;
        end else begin
            user_update_strobe <= '0;
            if (update_dr) begin
                for (int i = 0; i < N_USER; i++) begin
                    if (user_sel[i]) begin
                        user_update_data[i*W +: W] <= dr_sr[W-1:0];
                        user_update_strobe[i]      <= 1'b1;
                    end
                end
            end
        end
    end

    // Serial output launched on the falling edge
    always_ff @(negedge tck or negedge trst) begin
        if (!trst) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else begin
            tdo_en <= shift_ir | shift_dr;
            unique case (1'b1)
                shift_ir: tdo <= ir_sr[0];
                shift_dr: tdo <= dr_sr[0];
                default:  tdo <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_tap_multi_dr.sv
// Bench for jtag_tap_multi_dr.
// Table-driven TAP model plus directed and random scans.
module tb_jtag_tap_multi_dr;

    logic        tck  = 1'b0;
    logic        trst = 1'b1;
    logic        tms  = 1'b1;
    logic        tdi  = 1'b0;
    logic [63:0] cap_data = '0;
    logic        tdo;
    logic        tdo_en;
    logic [3:0]  ir_out;
    logic [63:0] upd_data;
    logic [1:0]  upd_stb;
    logic        tap_reset;

    jtag_tap_multi_dr #(
        .IR_WIDTH      (4),
        .N_USER        (2),
        .USER_DR_WIDTH (32),
        .IDCODE_VAL    (32'h1000_0001),
        .USER_BASE     (2)
    ) dut (
        .tck                (tck),
        .trst               (trst),
        .tms                (tms),
        .tdi                (tdi),
        .tdo                (tdo),
        .tdo_en             (tdo_en),
        .ir_out             (ir_out),
        .user_capture_data  (cap_data),
        .user_update_data   (upd_data),
        .user_update_strobe (upd_stb),
        .tap_reset          (tap_reset)
    );

    always #5 tck = ~tck;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4;
    localparam int EX1DR = 5, PDR = 6, EX2DR = 7, UPDDR = 8, SELIR = 9;
    localparam int CAPIR = 10, SHIR = 11, EX1IR = 12, PIR = 13;
    localparam int EX2IR = 14, UPDIR = 15;

    int nx0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nx1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

    int          st;
    int          mk;
    int          m_len;
    logic [3:0]  m_ir_sr;
    logic [3:0]  m_ir;
    logic [31:0] m_dr;
    logic [63:0] m_upd;
    logic [1:0]  m_stb;
    logic        e_tdo;
    logic        e_en;

    function automatic int user_of(input logic [3:0] ir);
        if (ir == 4'd2 || ir == 4'd3) return int'(ir) - 2;
        return -1;
    endfunction

    task automatic cmp(input string n, input logic [63:0] a,
                       input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e);
        end
    endtask

    // Reference model: one step per tck rise
    always @(posedge tck or negedge trst) begin
        if (!trst) begin
            st = TLR; m_ir_sr = '0; m_ir = 4'd1;
            m_dr = '0; m_len = 1; m_upd = '0; m_stb = '0;
        end else begin
            m_stb = '0;
            case (st)
                TLR:   m_ir = 4'd1;
                CAPIR: m_ir_sr = 4'b0001;
                SHIR:  m_ir_sr = {tdi, m_ir_sr[3:1]};
                UPDIR: m_ir = m_ir_sr;
                CAPDR: begin
                    mk = user_of(m_ir);
                    if (m_ir == 4'd1) begin
                        m_dr = 32'h1000_0001; m_len = 32;
                    end else if (mk >= 0) begin
                        m_dr = cap_data[mk*32 +: 32]; m_len = 32;
                    end else begin
                        m_dr = '0; m_len = 1;
                    end
                end
                SHDR: begin
                    m_dr = m_dr >> 1;
                    m_dr[m_len-1] = tdi;
                end
                UPDDR: begin
                    mk = user_of(m_ir);
                    if (mk >= 0) begin
                        m_upd[mk*32 +: 32] = m_dr;
                        m_stb[mk] = 1'b1;
                    end
                end
                default: ;
            endcase
            st = tms ? nx1[st] : nx0[st];
        end
    end

    // Compare every cycle after outputs settle on the fall
    always @(negedge tck) begin
        #1;
        if (chk_en) begin
            e_en  = (st == SHDR) || (st == SHIR);
            e_tdo = (st == SHIR) ? m_ir_sr[0] :
                    (st == SHDR) ? m_dr[0] : 1'b0;
            cmp("m_tap_reset", 64'(tap_reset), 64'(st == TLR));
            cmp("m_ir_out", 64'(ir_out), 64'(m_ir));
            cmp("m_tdo", 64'(tdo), 64'(e_tdo));
            cmp("m_tdo_en", 64'(tdo_en), 64'(e_en));
            cmp("m_upd_data", upd_data, m_upd);
            cmp("m_upd_stb", 64'(upd_stb), 64'(m_stb));
        end
    end

    task automatic step(input logic t, input logic d);
        tms = t;
        tdi = d;
        @(negedge tck);
        #2;
    endtask

    task automatic goto_tlr;
        repeat (5) step(1'b1, 1'b0);
    endtask

    task automatic load_ir(input logic [3:0] v);
        logic [3:0] o;
        o = '0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            o[i] = tdo;
            step(i == 3, v[i]);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        cmp("ir_capture", 64'(o), 64'h1);
        cmp("ir_load", 64'(ir_out), 64'(v));
    endtask

    task automatic enter_shift_dr;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic shift_dr(input int n, input logic [63:0] din,
                            input logic last_exit,
                            output logic [63:0] dout);
        dout = '0;
        for (int i = 0; i < n; i++) begin
            dout[i] = tdo;
            step(last_exit && (i == n - 1), din[i]);
        end
    endtask

    logic [63:0] d;
    logic [31:0] dv;

    initial begin
        #1 trst = 1'b0;
        @(negedge tck);
        #2 trst = 1'b1;
        chk_en = 1'b1;

        goto_tlr();
        cmp("rst_tap_reset", 64'(tap_reset), 64'h1);
        cmp("rst_ir_out", 64'(ir_out), 64'h1);
        cmp("rst_tdo_en", 64'(tdo_en), 64'h0);
        cmp("rst_upd_data", upd_data, 64'h0);

        step(1'b0, 1'b0);
        enter_shift_dr();
        shift_dr(32, 64'h0, 1'b1, d);
        cmp("idcode", d, 64'h1000_0001);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        cmp("idcode_no_stb", 64'(upd_stb), 64'h0);

        load_ir(4'hF);
        enter_shift_dr();
        shift_dr(3, 64'b101, 1'b1, d);
        cmp("bypass", d, 64'b010);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        cmp("bypass_no_stb", 64'(upd_stb), 64'h0);

        cap_data = {32'h0BAD_BEEF, 32'hCAFE_F00D};
        load_ir(4'd2);
        enter_shift_dr();
        shift_dr(32, 64'h1234_5678, 1'b1, d);
        cmp("user0_capture", d, 64'hCAFE_F00D);
        step(1'b1, 1'b0);
        cmp("user0_stb_pre", 64'(upd_stb), 64'h0);
        step(1'b0, 1'b0);
        cmp("user0_stb", 64'(upd_stb), 64'h1);
        cmp("user0_update", 64'(upd_data[31:0]), 64'h1234_5678);
        step(1'b0, 1'b0);
        cmp("user0_stb_post", 64'(upd_stb), 64'h0);

        dv = 32'hA5C3_1E97;
        load_ir(4'd3);
        enter_shift_dr();
        shift_dr(10, 64'(dv), 1'b1, d);
        cmp("user1_cap_lo", d, 64'(32'h0BAD_BEEF & 32'h3FF));
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        shift_dr(22, 64'(dv >> 10), 1'b1, d);
        cmp("user1_cap_hi", d, 64'(32'h0BAD_BEEF >> 10));
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        cmp("user1_stb", 64'(upd_stb), 64'h2);
        cmp("user1_update", 64'(upd_data[63:32]), 64'hA5C3_1E97);
        cmp("user0_kept", 64'(upd_data[31:0]), 64'h1234_5678);

        load_ir(4'd2);
        enter_shift_dr();
        shift_dr(5, 64'h1F, 1'b0, d);
        #1 trst = 1'b0;
        #1;
        cmp("trst_stb", 64'(upd_stb), 64'h0);
        cmp("trst_tap_reset", 64'(tap_reset), 64'h1);
        cmp("trst_ir_out", 64'(ir_out), 64'h1);
        cmp("trst_tdo_en", 64'(tdo_en), 64'h0);
        cmp("trst_upd_data", upd_data, 64'h0);
        @(negedge tck);
        #2 trst = 1'b1;
        step(1'b1, 1'b0);
        cmp("trst_stay_tlr", 64'(tap_reset), 64'h1);

        repeat (3000) begin
            cap_data = {$urandom(), $urandom()};
            if ($urandom_range(0, 399) == 0) begin
                #1 trst = 1'b0;
                @(negedge tck);
                #2 trst = 1'b1;
            end else begin
                step($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
